// File: rtl/turfio_clk_sequencer.sv
// turfio_clk_sequencer: TURFIO MMCM reset/lock sequencer and sysclk phase marker; define TURFIO_CLK_AUTORETRY_EN for auto-retry on lock failure
module turfio_clk_sequencer #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 65536
) (
   input  logic       sysclk_i,
   input  logic       rst_i,
   input  logic [1:0] reset_req_i,
   input  logic [1:0] locked_i,
   output logic [1:0] mmcm_rst_o,
   output logic       sysclk_phase_o,
   output logic [1:0] ready_o,
   output logic [1:0] fault_o,
   output logic [7:0] retry_count_o
);
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [1:0] ST_RESET     = 2'd0;
   localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
   localparam logic [1:0] ST_LOCKED    = 2'd2;
   localparam logic [1:0] ST_FAULT     = 2'd3;
   logic [2:0] phase_cnt;
   logic [1:0] lk_meta, lk;
   always_ff @(posedge sysclk_i or posedge rst_i)
      if (rst_i) begin
         phase_cnt      <= '0;
         sysclk_phase_o <= 1'b0;
         lk_meta        <= '0;
         lk             <= '0;
      end else begin
         phase_cnt      <= phase_cnt + 3'd1;
         sysclk_phase_o <= (phase_cnt == 3'd7);
         lk_meta        <= locked_i;
         lk             <= lk_meta;
      end
   for (genvar g = 0; g < 2; g++) begin : g_bank
      logic [1:0]    st;
      logic [RW-1:0] rcnt;
      logic [TW-1:0] tcnt;
      logic          fault, err;
`ifdef TURFIO_CLK_AUTORETRY_EN
      logic [3:0]    retry;
`endif
      // timeout and lock loss share one error path; lk winning in the timeout cycle counts as a lock
      assign err = ((st == ST_WAIT_LOCK) && !lk[g] && (tcnt == T_LAST)) || ((st == ST_LOCKED) && !lk[g]);
      always_ff @(posedge sysclk_i or posedge rst_i)
         if (rst_i) begin
            st    <= ST_RESET;
            rcnt  <= '0;
            tcnt  <= '0;
            fault <= 1'b0;
`ifdef TURFIO_CLK_AUTORETRY_EN
            retry <= '0;
`endif
         end else if (reset_req_i[g]) begin
            st    <= ST_RESET;
            rcnt  <= '0;
            tcnt  <= '0;
            fault <= 1'b0;
`ifdef TURFIO_CLK_AUTORETRY_EN
            retry <= '0;
`endif
         end else if (err) begin
            fault <= 1'b1;
            rcnt  <= '0;
            tcnt  <= '0;
`ifdef TURFIO_CLK_AUTORETRY_EN
            st    <= ST_RESET;
            retry <= retry + {3'd0, retry != 4'hf};
`else
            st    <= ST_FAULT;
`endif
         end else if (st == ST_RESET) begin
            rcnt <= rcnt + 1'b1;
            if (rcnt == R_LAST) begin
               st   <= ST_WAIT_LOCK;
               rcnt <= '0;
               tcnt <= '0;
            end
         end else if (st == ST_WAIT_LOCK) begin
            tcnt <= tcnt + 1'b1;
            if (lk[g]) st <= ST_LOCKED;
         end
      assign mmcm_rst_o[g] = (st == ST_RESET) || (st == ST_FAULT);
      assign ready_o[g]    = (st == ST_LOCKED);
      assign fault_o[g]    = fault;
`ifdef TURFIO_CLK_AUTORETRY_EN
      assign retry_count_o[4*g +: 4] = retry;
`else
      assign retry_count_o[4*g +: 4] = 4'd0;
`endif
   end
endmodule

// File: doc/turfio_clk_sequencer.md
# turfio_clk_sequencer

Reset/lock sequencer for the two TURFIO interface MMCMs (banks 67 and 68), running in the sysclk domain. It generates the 8-cycle sysclk phase marker that the interface-clock block uses to align its phase counters. It also drives each MMCM's reset, times out on lock, and reports per-bank ready/fault status and retry counts to the control registers.

## Interface
Parameters:
- RST_CYCLES, 16: cycles `mmcm_rst_o[n]` is held high per reset attempt (≥2).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before declaring a timeout (≥4).

Ports:
- `sysclk_i`  in  1  system clock, 125 MHz; the only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `reset_req_i`  in  2  per-bank single-cycle restart request; bit 0 = bank 67, bit 1 = bank 68.
- `locked_i`  in  2  raw MMCM LOCKED, asynchronous to `sysclk_i`.
- `mmcm_rst_o`  out  2  MMCM reset; feeds the bank 67 and bank 68 MMCM resets.
- `sysclk_phase_o`  out  1  one-cycle pulse every 8 cycles marking phase 0.
- `ready_o`  out  2  bank is locked and stable.
- `fault_o`  out  2  sticky: lock timeout or lock loss since the last request.
- `retry_count_o`  out  8  per-bank auto-retry count; [3:0] = bank 67, [7:4] = bank 68; saturates at 15.

## Operation
- Phase marker:
  - 3-bit free-running counter, reset to 0.
  - `sysclk_phase_o` is registered and is high exactly in the cycle after the counter equals 7.
- Lock input:
  - `locked_i[n]` passes through a 2-flop synchronizer, reset to 0, giving `lk[n]`.
- Per-bank FSM, two identical independent instances with states RESET, WAIT_LOCK, LOCKED, FAULT:
  - RESET: `mmcm_rst_o` = 1; count RST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: `mmcm_rst_o` = 0; count cycles.
    - `lk` = 1 → LOCKED.
    - Count reaches LOCK_TIMEOUT with `lk` = 0 → set `fault_o`, then take the error path.
  - LOCKED: `ready_o` = 1.
    - `lk` = 0 → set `fault_o`, clear `ready_o`, take the error path.
  - FAULT: `mmcm_rst_o` = 1 and `ready_o` = 0; leave only on `reset_req_i`.
  - Error path: defined under Configuration.
- `reset_req_i[n]`, in any state:
  - Go to RESET, restart the RST_CYCLES count.
  - Clear `fault_o[n]` and the retry count for that bank.
  - Drop `ready_o[n]` on the next edge.
- Priority when events coincide in the same cycle: request > timeout/lock loss > normal transition.
- The two banks never interact. A request to one bank leaves the other bank's state, counters and outputs unchanged.
- The phase counter is unaffected by the bank FSMs and by `reset_req_i`.

## Timing
- Values while `rst_i` is high and just after release:
  - `mmcm_rst_o` = 2'b11
  - `sysclk_phase_o` = 0
  - `ready_o` = 0
  - `fault_o` = 0
  - `retry_count_o` = 0
  - both FSMs in RESET with count 0; power-up entry into RESET counts as the initial attempt, not a retry.
- After `rst_i` deasserts:
  - `mmcm_rst_o[n]` stays high for exactly RST_CYCLES rising edges.
  - The first `sysclk_phase_o` pulse is on the 8th edge; subsequent pulses follow every 8 edges.
- Lock latency:
  - `locked_i` rising → `ready_o` high after 3 edges (2 synchronizer edges + 1 FSM edge).
  - `locked_i` falling → `ready_o` low and `fault_o` high after 3 edges.
- Request latency: `reset_req_i` sampled high → `mmcm_rst_o` high at the next edge.
- Timeout: counted from WAIT_LOCK entry; the timeout fires on the cycle the count equals LOCK_TIMEOUT−1.
- Counter widths:
  - reset counter: $clog2(RST_CYCLES+1) bits.
  - timeout counter: $clog2(LOCK_TIMEOUT+1) bits.
- If `rst_i` is asserted mid-operation, all outputs return asynchronously to their reset values.

## Configuration
- Macro `TURFIO_CLK_AUTORETRY_EN`:
  - Defined: the error path goes to RESET and increments that bank's retry count, saturating at 15. FAULT is unreachable. `fault_o` stays sticky.
  - Undefined: the error path goes to FAULT. `retry_count_o` is tied to 0.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=100.
- Release `rst_i` with `locked_i` = 0 → `mmcm_rst_o` = 2'b11 for 4 edges, then 2'b00; `sysclk_phase_o` pulses on edges 8, 16 and 24.
- Raise `locked_i[0]` 10 cycles into WAIT_LOCK → `ready_o[0]` = 1 3 edges later; `ready_o[1]` remains 0.
- Hold `locked_i[1]` = 0:
  - Macro undefined: `fault_o[1]` = 1 after 100 WAIT_LOCK cycles, FSM in FAULT, `mmcm_rst_o[1]` = 1.
  - Macro defined: the bank re-enters RESET and `retry_count_o[7:4]` = 1, 2, … up to 15, then holds.
- Drop `locked_i[0]` while LOCKED → `ready_o[0]` = 0 and `fault_o[0]` = 1 after 3 edges. Then pulse `reset_req_i[0]` → `fault_o[0]` = 0, `retry_count_o[3:0]` = 0, `mmcm_rst_o[0]` = 1 for 4 edges.
- Assert `reset_req_i[0]` in the same cycle as the lock timeout → request wins: `fault_o[0]` stays 0, the retry count is not incremented, and the RESET count restarts at 0.
- Assert `rst_i` in the middle of WAIT_LOCK → outputs return to their reset values asynchronously, and the phase counter restarts so the first pulse is again on the 8th edge after release.
